dispense_cmd_responder: RTL and testbench
=========================================

Name: dispense_cmd_responder

Overview:
- FPGA-side responder for the Raspberry Pi dispense command interface. The Pi drives teststate[2:0], stateamount[1:0] and the candyflag request line.
- The block synchronizes and qualifies these lines, then issues one command pulse to the stepper/DC motor controllers.
- It returns a 4-phase handshake to the Pi on ack_out, done_out and err_out.
- It sits between the Pi I/O pins and the motor control logic in project_module.

Parameters:
- SYNC_STAGES, 2: flip-flop stages per raw Pi input (minimum 2).
- STABLE_CYCLES, 1200: cycles the request fields must hold unchanged before acceptance (100 us at 12 MHz).
- TIMEOUT_CYCLES, 120000000: maximum RUN duration before error (10 s at 12 MHz).

Ports:
- clk_x1  input  1  12 MHz system clock.
- rstn  input  1  asynchronous active-low reset.
- teststate_in  input  3  raw Pi test/dispense state (IO_B6,IO_B5,IO_B4).
- stateamount_in  input  2  raw Pi amount code (IO_A4,IO_A3).
- candyflag_in  input  1  raw Pi request line.
- motor_done  input  1  one-cycle pulse from motor control: dispense finished.
- cmd_valid  output  1  one-cycle command strobe to motor control.
- cmd_state  output  3  qualified teststate; valid while cmd_valid=1, held until next issue.
- cmd_amount  output  2  qualified amount; same timing as cmd_state.
- ack_out  output  1  to Pi: request accepted / busy.
- done_out  output  1  to Pi: dispense complete.
- err_out  output  1  to Pi: request rejected or timed out.

Behaviour:
- One clock (clk_x1). rstn is asynchronous and active-low.
- All raw inputs pass through SYNC_STAGES flops, reset to 0. Only synchronized values (flag_s, state_s, amt_s) are used.
- Reset values: all outputs 0, FSM=IDLE, counters 0, armed=0, captured fields 0.
- Arming: armed sets on the first cycle with flag_s=0 and never clears until reset. A request already high across reset is never executed.
- States and transitions:
  - IDLE: outputs low. If armed and flag_s=1, capture state_s/amt_s, clear the counter, go to QUALIFY.
  - QUALIFY:
    - flag_s=0 → IDLE.
    - state_s/amt_s differ from captured → recapture and restart the count.
    - Counter reaches STABLE_CYCLES-1 with no change → if captured state=3'b000 go to ERROR, else go to ISSUE.
  - ISSUE (exactly 1 cycle): cmd_valid=1; cmd_state/cmd_amount=captured; ack_out=1; clear the timeout counter. Next state is RUN, or DONE if motor_done=1 in this same cycle.
  - RUN: ack_out=1. The counter increments each cycle.
    - motor_done=1 → DONE.
    - Counter reaches TIMEOUT_CYCLES-1 without motor_done → ERROR.
    - motor_done and timeout in the same cycle → DONE wins.
    - flag_s dropping in RUN is ignored; the command is committed.
  - DONE: ack_out=1, done_out=1. When flag_s=0 → IDLE, and ack/done fall on the transition cycle.
  - ERROR: ack_out=1, err_out=1. When flag_s=0 → IDLE, clearing both.
- motor_done outside ISSUE/RUN is ignored.
- Latency: cmd_valid asserts SYNC_STAGES+STABLE_CYCLES+1 cycles after candyflag_in rises, given fields stable and set up with the flag.
- Counters: the qualify counter is clog2(STABLE_CYCLES) bits and the timeout counter clog2(TIMEOUT_CYCLES) bits. Both saturate (no wrap) and clear on every state entry.
- Reset mid-operation clears everything immediately. cmd_valid never glitches high.
- After reset, the Pi must drop candyflag before any new request is honoured.
- Outputs are registered (Moore); no combinational path from inputs to outputs.

Test Plan:
(Overrides: STABLE_CYCLES=4, TIMEOUT_CYCLES=50, SYNC_STAGES=2.)
- Normal dispense: drop flag after reset, then set state=3'b011, amt=2'b10, raise flag → cmd_valid high for 1 cycle, 7 cycles after the flag edge, with cmd_state=3, cmd_amount=2 and ack_out=1. Pulse motor_done → done_out=1. Drop flag → ack/done return to 0 and FSM returns to IDLE.
- Field change during qualify: flag high with state=3'b001, switch to 3'b101 after 2 cycles → qualification restarts; a single cmd_valid carries cmd_state=5.
- Aborted request: flag high for 3 cycles then low → no cmd_valid, ack_out stays 0.
- Invalid and timeout:
  - state=3'b000 with flag high → err_out=1, no cmd_valid.
  - Separately, a valid request with no motor_done → err_out=1 after 50 RUN cycles.
  - In both cases err_out clears when the flag drops.
- Simultaneity: motor_done on the ISSUE cycle → DONE directly. motor_done together with the timeout cycle → done_out=1, err_out=0.
- Reset behaviour:
  - Reset asserted in RUN → all outputs 0 asynchronously.
  - Release reset with flag still high → no cmd_valid until the flag goes low then high again.

Source files
------------

// File: rtl/dispense_cmd_if.sv
// Pi/motor-facing signal bundle for the dispense command responder.
// master drives the raw request and motor feedback; slave is the responder.
interface dispense_cmd_if;
    logic [2:0] teststate_in;
    logic [1:0] stateamount_in;
    logic       candyflag_in;
    logic       motor_done;
    logic       cmd_valid;
    logic [2:0] cmd_state;
    logic [1:0] cmd_amount;
    logic       ack_out;
    logic       done_out;
    logic       err_out;

    modport master (
        output teststate_in, stateamount_in, candyflag_in, motor_done,
        input  cmd_valid, cmd_state, cmd_amount, ack_out, done_out, err_out
    );

    modport slave (
        input  teststate_in, stateamount_in, candyflag_in, motor_done,
        output cmd_valid, cmd_state, cmd_amount, ack_out, done_out, err_out
    );
endinterface

// File: rtl/dispense_cmd_responder.sv
// Synchronizes and qualifies the Pi dispense request, issues one motor command
// strobe and runs the ack/done/err handshake back to the Pi.
module dispense_cmd_responder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 1200,
    parameter int unsigned TIMEOUT_CYCLES = 120000000
) (
    input  logic          clk_x1,
    input  logic          rstn,
    dispense_cmd_if.slave bus
);
    localparam int unsigned QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [QW-1:0] QMAX = QW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_QUALIFY = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERROR   = 3'd5;

    logic [5:0]             sync_r [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] prime_r;
    logic                   armed_r;
    logic [2:0]             state_r, state_nx;
    logic [2:0]             cap_state_r, cap_state_nx;
    logic [1:0]             cap_amt_r, cap_amt_nx;
    logic [QW-1:0]          qcnt_r, qcnt_nx;
    logic [TW-1:0]          tcnt_r, tcnt_nx;
    logic                   recap_s;
    logic                   cmd_valid_r, ack_r, done_r, err_r;
    logic [2:0]             cmd_state_r;
    logic [1:0]             cmd_amount_r;

    logic       flag_s;
    logic [2:0] state_s;
    logic [1:0] amt_s;
    logic       primed_s;

    assign flag_s   = sync_r[SYNC_STAGES-1][0];
    assign amt_s    = sync_r[SYNC_STAGES-1][2:1];
    assign state_s  = sync_r[SYNC_STAGES-1][5:3];
    // prime_r marks when the sync chain holds real pin samples rather than reset zeros,
    // so a request held high across reset cannot arm the block.
    assign primed_s = prime_r[SYNC_STAGES-1];

    // Input synchronizer chain and fill tracker.
    always_ff @(posedge clk_x1 or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 6'd0;
            prime_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r[0] <= {bus.teststate_in, bus.stateamount_in, bus.candyflag_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
            prime_r <= {prime_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Next-state and field-capture logic.
    always_comb begin
        state_nx     = state_r;
        cap_state_nx = cap_state_r;
        cap_amt_nx   = cap_amt_r;
        recap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (armed_r && flag_s) begin
                    state_nx     = ST_QUALIFY;
                    cap_state_nx = state_s;
                    cap_amt_nx   = amt_s;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_QUALIFY: begin
                if (!flag_s) begin
                    state_nx = ST_IDLE;
                end else if ((state_s != cap_state_r) || (amt_s != cap_amt_r)) begin
                    cap_state_nx = state_s;
                    cap_amt_nx   = amt_s;
                    recap_s      = 1'b1;
                end else if (qcnt_r == QMAX) begin
                    state_nx = (cap_state_r == 3'b000) ? ST_ERROR : ST_ISSUE;
                end else begin
                    state_nx = ST_QUALIFY;
                end
            end
            ST_ISSUE: state_nx = bus.motor_done ? ST_DONE : ST_RUN;
            ST_RUN: begin
                // Completion beats a coincident timeout.
                if (bus.motor_done) begin
                    state_nx = ST_DONE;
                end else if (tcnt_r == TMAX) begin
                    state_nx = ST_ERROR;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!flag_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = state_r;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Saturating counters, cleared on every state entry or recapture.
    always_comb begin
        qcnt_nx = qcnt_r;
        tcnt_nx = tcnt_r;
        if ((state_nx != state_r) || recap_s) begin
            qcnt_nx = {QW{1'b0}};
            tcnt_nx = {TW{1'b0}};
        end else begin
            if ((state_r == ST_QUALIFY) && (qcnt_r != QMAX)) begin
                qcnt_nx = qcnt_r + QW'(1);
            end else begin
                qcnt_nx = qcnt_r;
            end
            if ((state_r == ST_RUN) && (tcnt_r != TMAX)) begin
                tcnt_nx = tcnt_r + TW'(1);
            end else begin
                tcnt_nx = tcnt_r;
            end
        end
    end

    // FSM state, arming, captured fields and counters.
    always_ff @(posedge clk_x1 or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            armed_r     <= 1'b0;
            cap_state_r <= 3'd0;
            cap_amt_r   <= 2'd0;
            qcnt_r      <= {QW{1'b0}};
            tcnt_r      <= {TW{1'b0}};
        end else begin
            state_r     <= state_nx;
            armed_r     <= armed_r | (primed_s & ~flag_s);
            cap_state_r <= cap_state_nx;
            cap_amt_r   <= cap_amt_nx;
            qcnt_r      <= qcnt_nx;
            tcnt_r      <= tcnt_nx;
        end
    end

    // Registered Moore outputs decoded from the next state.
    always_ff @(posedge clk_x1 or negedge rstn) begin
        if (!rstn) begin
            cmd_valid_r  <= 1'b0;
            cmd_state_r  <= 3'd0;
            cmd_amount_r <= 2'd0;
            ack_r        <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            cmd_valid_r <= (state_nx == ST_ISSUE);
            if (state_nx == ST_ISSUE) begin
                cmd_state_r  <= cap_state_r;
                cmd_amount_r <= cap_amt_r;
            end else begin
                cmd_state_r  <= cmd_state_r;
                cmd_amount_r <= cmd_amount_r;
            end
            ack_r  <= (state_nx inside {ST_ISSUE, ST_RUN, ST_DONE, ST_ERROR});
            done_r <= (state_nx == ST_DONE);
            err_r  <= (state_nx == ST_ERROR);
        end
    end

    assign bus.cmd_valid  = cmd_valid_r;
    assign bus.cmd_state  = cmd_state_r;
    assign bus.cmd_amount = cmd_amount_r;
    assign bus.ack_out    = ack_r;
    assign bus.done_out   = done_r;
    assign bus.err_out    = err_r;
endmodule

// File: tb/tb_dispense_cmd_responder.sv
// Randomized self-checking bench for dispense_cmd_responder; expected timing is
// derived from edge-count arithmetic on the request/handshake rules.
module tb_dispense_cmd_responder;
    localparam int SYNC    = 2;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 50;
    localparam int LAT     = SYNC + STABLE + 1;

    logic clk_x1 = 1'b0;
    logic rstn   = 1'b0;
    int checks = 0;
    int errors = 0;
    int cv_n = 0;

    dispense_cmd_if bus();

    dispense_cmd_responder #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) u_dut (
        .clk_x1(clk_x1), .rstn(rstn), .bus(bus)
    );

    always #5 clk_x1 = ~clk_x1;

    // Count command strobes, sampled away from the active edge.
    always @(negedge clk_x1) begin
        if (bus.cmd_valid === 1'b1) cv_n <= cv_n + 1;
    end

    function automatic logic [8:0] outs();
        return {bus.cmd_valid, bus.cmd_state, bus.cmd_amount, bus.ack_out, bus.done_out, bus.err_out};
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk_x1); #1; end
    endtask

    task automatic raise(input logic [2:0] st, input logic [1:0] am);
        bus.teststate_in = st; bus.stateamount_in = am; bus.candyflag_in = 1'b1;
    endtask

    task automatic wait_cmd(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step(1);
            if (bus.cmd_valid === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic pulse_done();
        bus.motor_done = 1'b1; step(1); bus.motor_done = 1'b0;
    endtask

    task automatic go_idle();
        bus.candyflag_in = 1'b0; bus.motor_done = 1'b0; step(SYNC + 2);
    endtask

    task automatic test_reset();
        bus.teststate_in = 3'd0; bus.stateamount_in = 2'd0;
        bus.candyflag_in = 1'b0; bus.motor_done = 1'b0;
        rstn = 1'b0; step(3);
        checks++;
        if (outs() !== 9'd0) begin errors++; $display("FAIL reset_outs got %b want %b", outs(), 9'd0); end
        rstn = 1'b1; step(SYNC + 2);
        checks++;
        if (outs() !== 9'd0) begin errors++; $display("FAIL post_reset_outs got %b want %b", outs(), 9'd0); end
    endtask

    task automatic test_normal();
        for (int it = 0; it < 6; it++) begin
            logic [2:0] st; logic [1:0] am; int d; int n; int base;
            st = 3'($urandom_range(7, 1)); am = 2'($urandom_range(3, 0));
            d = $urandom_range(TIMEOUT - 1, 1);
            base = cv_n;
            raise(st, am); wait_cmd(n);
            checks++;
            if (n !== LAT) begin errors++; $display("FAIL normal_latency got %0d want %0d", n, LAT); end
            checks++;
            if ({bus.cmd_state, bus.cmd_amount, bus.ack_out} !== {st, am, 1'b1})
                begin errors++; $display("FAIL normal_cmd got %b want %b", {bus.cmd_state, bus.cmd_amount, bus.ack_out}, {st, am, 1'b1}); end
            step(d); pulse_done();
            checks++;
            if ({bus.cmd_valid, bus.cmd_state, bus.ack_out, bus.done_out, bus.err_out} !== {1'b0, st, 3'b110})
                begin errors++; $display("FAIL normal_done got %b want %b", {bus.cmd_valid, bus.cmd_state, bus.ack_out, bus.done_out, bus.err_out}, {1'b0, st, 3'b110}); end
            checks++;
            if (cv_n - base !== 1) begin errors++; $display("FAIL normal_strobes got %0d want 1", cv_n - base); end
            bus.candyflag_in = 1'b0; step(SYNC);
            checks++;
            if ({bus.ack_out, bus.done_out} !== 2'b11) begin errors++; $display("FAIL normal_hold got %b want 11", {bus.ack_out, bus.done_out}); end
            step(1);
            checks++;
            if ({bus.ack_out, bus.done_out, bus.err_out} !== 3'b000) begin errors++; $display("FAIL normal_release got %b want 000", {bus.ack_out, bus.done_out, bus.err_out}); end
            step(1);
        end
    endtask

    task automatic test_field_change();
        int ks[3];
        ks[0] = 2; ks[1] = 4; ks[2] = $urandom_range(4, 1);
        foreach (ks[j]) begin
            logic [2:0] st1, st2; int n; int base;
            st1 = (j == 0) ? 3'b001 : 3'($urandom_range(7, 1));
            st2 = (j == 0) ? 3'b101 : st1;
            while (st2 == st1) st2 = 3'($urandom_range(7, 1));
            base = cv_n;
            raise(st1, 2'($urandom_range(3, 0))); step(ks[j]);
            bus.teststate_in = st2; wait_cmd(n);
            checks++;
            if (n !== LAT) begin errors++; $display("FAIL change_latency k=%0d got %0d want %0d", ks[j], n, LAT); end
            checks++;
            if (bus.cmd_state !== st2) begin errors++; $display("FAIL change_state got %0d want %0d", bus.cmd_state, st2); end
            pulse_done(); go_idle();
            checks++;
            if (cv_n - base !== 1) begin errors++; $display("FAIL change_strobes got %0d want 1", cv_n - base); end
        end
    endtask

    task automatic test_abort();
        int hs[4];
        hs[0] = 3; hs[1] = STABLE; hs[2] = STABLE + 1; hs[3] = $urandom_range(STABLE, 1);
        foreach (hs[j]) begin
            int base; logic ack_seen; logic issued;
            issued = (hs[j] >= STABLE + 1);
            base = cv_n; ack_seen = 1'b0;
            raise(3'($urandom_range(7, 1)), 2'($urandom_range(3, 0)));
            for (int i = 0; i < hs[j]; i++) begin step(1); ack_seen |= bus.ack_out; end
            bus.candyflag_in = 1'b0;
            for (int i = 0; i < 20 + (issued ? TIMEOUT + 5 : 0); i++) begin step(1); ack_seen |= bus.ack_out; end
            checks++;
            if (cv_n - base !== int'(issued)) begin errors++; $display("FAIL abort_strobes h=%0d got %0d want %0d", hs[j], cv_n - base, int'(issued)); end
            checks++;
            if (ack_seen !== issued) begin errors++; $display("FAIL abort_ack h=%0d got %b want %b", hs[j], ack_seen, issued); end
            go_idle();
        end
    endtask

    task automatic test_invalid();
        int n; int base;
        base = cv_n; n = -1;
        raise(3'b000, 2'($urandom_range(3, 0)));
        for (int i = 1; i <= 100; i++) begin step(1); if (bus.err_out === 1'b1) begin n = i; break; end end
        checks++;
        if (n !== LAT) begin errors++; $display("FAIL invalid_latency got %0d want %0d", n, LAT); end
        checks++;
        if ({cv_n - base, bus.ack_out, bus.done_out} !== {32'd0, 2'b10}) begin errors++; $display("FAIL invalid_flags strobes %0d ack %b done %b want 0 1 0", cv_n - base, bus.ack_out, bus.done_out); end
        bus.candyflag_in = 1'b0; step(SYNC + 1);
        checks++;
        if ({bus.ack_out, bus.err_out} !== 2'b00) begin errors++; $display("FAIL invalid_clear got %b want 00", {bus.ack_out, bus.err_out}); end
        step(1);
    endtask

    task automatic test_timeout();
        int n; int t;
        raise(3'($urandom_range(7, 1)), 2'($urandom_range(3, 0))); wait_cmd(n);
        t = -1;
        for (int i = 1; i <= 200; i++) begin step(1); if (bus.err_out === 1'b1) begin t = i; break; end end
        checks++;
        if (t !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", t, TIMEOUT + 1); end
        pulse_done(); step(1);
        checks++;
        if ({bus.ack_out, bus.done_out, bus.err_out} !== 3'b101) begin errors++; $display("FAIL timeout_flags got %b want 101", {bus.ack_out, bus.done_out, bus.err_out}); end
        bus.candyflag_in = 1'b0; step(SYNC + 1);
        checks++;
        if ({bus.ack_out, bus.err_out} !== 2'b00) begin errors++; $display("FAIL timeout_clear got %b want 00", {bus.ack_out, bus.err_out}); end
        step(1);
    endtask

    task automatic test_simultaneity();
        int ds[3];
        ds[0] = 0; ds[1] = TIMEOUT; ds[2] = TIMEOUT + 1;
        foreach (ds[j]) begin
            int n; logic [1:0] want;
            want = (ds[j] <= TIMEOUT) ? 2'b10 : 2'b01;
            raise(3'($urandom_range(7, 1)), 2'($urandom_range(3, 0))); wait_cmd(n);
            step(ds[j]); pulse_done();
            checks++;
            if ({bus.done_out, bus.err_out} !== want) begin errors++; $display("FAIL simul d=%0d got %b want %b", ds[j], {bus.done_out, bus.err_out}, want); end
            go_idle();
        end
    endtask

    task automatic test_reset_mid_run();
        int n; int base;
        raise(3'($urandom_range(7, 1)), 2'($urandom_range(3, 0))); wait_cmd(n); step(5);
        @(posedge clk_x1); #2 rstn = 1'b0; #1;
        checks++;
        if (outs() !== 9'd0) begin errors++; $display("FAIL async_reset got %b want %b", outs(), 9'd0); end
        step(3); rstn = 1'b1;
        base = cv_n; step(30);
        checks++;
        if ({cv_n - base, bus.ack_out} !== {32'd0, 1'b0}) begin errors++; $display("FAIL held_flag strobes %0d ack %b want 0 0", cv_n - base, bus.ack_out); end
        bus.candyflag_in = 1'b0; step(SYNC + 2);
        bus.candyflag_in = 1'b1; wait_cmd(n);
        checks++;
        if (n !== LAT) begin errors++; $display("FAIL rearm_latency got %0d want %0d", n, LAT); end
        pulse_done(); go_idle();
    endtask

    initial begin
        test_reset();
        go_idle();
        test_normal();
        test_field_change();
        test_abort();
        test_invalid();
        test_timeout();
        test_simultaneity();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
